// File: rtl/fp_booth_seq_multiplier.sv
// Iterative floating-point multiplier: one radix-4 Booth partial product per cycle,
// valid/ready on both sides. Define FP_MUL_RNE_EN for round-to-nearest-even, else truncation.
module fp_booth_seq_multiplier #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned BIAS  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_p,
    output logic [1:0]               out_exc,
    output logic                     busy
);

    localparam int unsigned N_ITER = (MAN_W + 3) / 2;
    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned QW     = 2 * N_ITER;
    localparam int unsigned AW     = QW + 2;
    localparam int unsigned PW     = 2 * QW;
    localparam int unsigned EW     = EXP_W + 2;
    localparam int unsigned CW     = $clog2(N_ITER + 1);
    localparam int unsigned PT     = 2 * MAN_W + 1;
    localparam int unsigned MW1    = MAN_W + 1;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 2);
    localparam logic signed [EW-1:0] E_MIN = EW'(1);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_hi_q, acc_hi_d;
    logic [QW-1:0]        acc_lo_q, acc_lo_d;
    logic                 q_m1_q, q_m1_d;
    logic [AW-1:0]        mcand_q, mcand_d;
    logic                 sign_q, sign_d;
    logic                 nan_q, nan_d;
    logic                 zero_q, zero_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [W-1:0]         out_p_q, out_p_d;
    logic [1:0]           out_exc_q, out_exc_d;

    logic [EXP_W-1:0]     a_exp, b_exp;
    logic                 a_nan, b_nan, a_zero, b_zero;
    logic [AW-1:0]        pp, sum;
    logic [AW+QW:0]       step_full;
    logic [PW-1:0]        prod, norm;
    logic                 top;
    logic [MAN_W-1:0]     mant, mant_fin;
    logic signed [EW-1:0] e_norm, e_fin;
    logic [W-1:0]         res_p;
    logic [1:0]           res_exc;
    logic                 unused_bits;

    assign a_exp  = in_a[W-2 -: EXP_W];
    assign b_exp  = in_b[W-2 -: EXP_W];
    assign a_nan  = &a_exp;
    assign b_nan  = &b_exp;
    assign a_zero = ~|a_exp;
    assign b_zero = ~|b_exp;

    // Booth recoding of {q1, q0, q-1}; multiples are two's complement in AW bits.
    always_comb begin
        pp = '0;
        unique case ({acc_lo_q[1:0], q_m1_q})
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    assign sum       = acc_hi_q + pp;
    assign step_full = $signed({sum, acc_lo_q, q_m1_q}) >>> 2;
    assign prod      = {acc_hi_q[QW-1:0], acc_lo_q};

    `ifdef FP_MUL_RNE_EN
    logic round_up, carry;
    `endif

    always_comb begin
        top    = prod[PT];
        norm   = top ? prod : (prod << 1);
        mant   = norm[PT-1 -: MAN_W];
        e_norm = exp_q + $signed({{(EW-1){1'b0}}, top});
`ifdef FP_MUL_RNE_EN
        // Guard is the first dropped bit; everything below it folds into sticky.
        round_up          = norm[MAN_W] & ((|norm[MAN_W-1:0]) | mant[0]);
        {carry, mant_fin} = {1'b0, mant} + MW1'(round_up);
        e_fin             = e_norm + $signed({{(EW-1){1'b0}}, carry});
`else
        mant_fin = mant;
        e_fin    = e_norm;
`endif
        res_p   = {sign_q, {(W-1){1'b0}}};
        res_exc = 2'b00;
        if (nan_q) begin
            res_p   = {sign_q, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            res_exc = 2'b11;
        end else if (zero_q) begin
            res_p   = {sign_q, {(W-1){1'b0}}};
            res_exc = 2'b00;
        end else if (e_fin > E_MAX) begin
            res_p   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_exc = 2'b01;
        end else if (e_fin < E_MIN) begin
            res_p   = {sign_q, {(W-1){1'b0}}};
            res_exc = 2'b10;
        end else begin
            res_p   = {sign_q, e_fin[EXP_W-1:0], mant_fin};
            res_exc = 2'b00;
        end
    end

    assign unused_bits = ^{acc_hi_q[AW-1:QW], norm};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        q_m1_d    = q_m1_q;
        mcand_d   = mcand_q;
        sign_d    = sign_q;
        nan_d     = nan_q;
        zero_d    = zero_q;
        exp_d     = exp_q;
        out_p_d   = out_p_q;
        out_exc_d = out_exc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_hi_d = '0;
                    acc_lo_d = QW'({1'b1, in_b[MAN_W-1:0]});
                    q_m1_d   = 1'b0;
                    mcand_d  = AW'({1'b1, in_a[MAN_W-1:0]});
                    cnt_d    = '0;
                    sign_d   = in_a[W-1] ^ in_b[W-1];
                    nan_d    = a_nan | b_nan;
                    zero_d   = a_zero | b_zero;
                    exp_d    = $signed(EW'(a_exp)) + $signed(EW'(b_exp)) - $signed(EW'(BIAS));
                    state_d  = (a_nan | b_nan | a_zero | b_zero) ? StNorm : StMul;
                end
            end
            StMul: begin
                acc_hi_d = step_full[AW+QW:QW+1];
                acc_lo_d = step_full[QW:1];
                q_m1_d   = step_full[0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N_ITER - 1)) state_d = StNorm;
            end
            StNorm: begin
                out_p_d   = res_p;
                out_exc_d = res_exc;
                state_d   = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            q_m1_q    <= 1'b0;
            mcand_q   <= '0;
            sign_q    <= 1'b0;
            nan_q     <= 1'b0;
            zero_q    <= 1'b0;
            exp_q     <= '0;
            out_p_q   <= '0;
            out_exc_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            q_m1_q    <= q_m1_d;
            mcand_q   <= mcand_d;
            sign_q    <= sign_d;
            nan_q     <= nan_d;
            zero_q    <= zero_d;
            exp_q     <= exp_d;
            out_p_q   <= out_p_d;
            out_exc_q <= out_exc_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_p     = out_p_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_fp_booth_seq_multiplier.sv
// Scoreboard bench for fp_booth_seq_multiplier (binary16 defaults): directed cases plus
// random operands against an integer-arithmetic reference model.
module tb_fp_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_a, in_b, out_p;
    logic [1:0]  out_exc;

    always #5 clk = ~clk;

    fp_booth_seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_exc   (out_exc),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] p;
        logic [1:0]  exc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   bp_mode = 1'b0;
    bit   prev_valid = 1'b0;
    bit   prev_cons = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product of the significands, then normalise and round.
    task automatic ref_mul(input logic [15:0] a, input logic [15:0] b, output exp_t e);
        logic s;
        int   ea, eb, ex, sh, mant;
        longint prd, rem, half;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        e.acc = 0;
        if (ea == 31 || eb == 31) begin
            e.p = {s, 5'h1f, 1'b1, 9'h0}; e.exc = 2'b11; e.lat = 2;
        end else if (ea == 0 || eb == 0) begin
            e.p = {s, 15'h0}; e.exc = 2'b00; e.lat = 2;
        end else begin
            e.lat = 8;
            prd = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
            ex  = ea + eb - 15;
            if (prd >= (64'sd1 << 21)) begin sh = 11; ex++; end
            else sh = 10;
            mant = int'(prd >> sh) - 1024;
            rem  = prd & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
            if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
            if (mant == 1024) begin mant = 0; ex++; end
`else
            if (rem > half) mant = mant + 0;
`endif
            if (ex > 30) begin
                e.p = {s, 5'h1f, 10'h0}; e.exc = 2'b01;
            end else if (ex < 1) begin
                e.p = {s, 15'h0}; e.exc = 2'b10;
            end else begin
                e.p = {s, 5'(ex), 10'(mant)}; e.exc = 2'b00;
            end
        end
    endtask

    // Called just after a posedge; returns just after the posedge that accepts.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int n = 0;
        bit ok = 1'b0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
                n++;
            end
        end
        if (ok) begin
            e.acc = cyc; last_acc = cyc; sb.push_back(e);
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        ref_mul(a, b, e);
        drive(a, b, e);
    endtask

    task automatic issue_k(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] p, input logic [1:0] exc);
        exp_t e;
        ref_mul(a, b, e);
        e.p = p; e.exc = exc;
        drive(a, b, e);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
        #1;
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
        end
    endtask

    function automatic logic [15:0] rand_op();
        int r = $urandom_range(0, 15);
        logic [4:0] ex;
        if (r == 0) ex = 5'h1f;
        else if (r == 1) ex = 5'h00;
        else ex = 5'($urandom_range(1, 30));
        return {1'($urandom_range(0, 1)), ex, 10'($urandom_range(0, 1023))};
    endfunction

    // Monitor: compares the queue head on every valid cycle, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0; prev_cons = 1'b0;
            end else begin
                if (prev_cons) chk("valid_one_cycle", 32'(out_valid), 32'd0);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got 0x%0h required no output", out_p);
                    end else begin
                        if (!prev_valid) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        chk("out_p", 32'(out_p), 32'(sb[0].p));
                        chk("out_exc", 32'(out_exc), 32'(sb[0].exc));
                        chk("in_ready_low", 32'(in_ready), 32'd0);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                prev_valid = out_valid;
                prev_cons  = out_valid && out_ready;
            end
        end
    end

    initial begin
        int rel, n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_p", 32'(out_p), 32'd0);
        chk("rst_out_exc", 32'(out_exc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue_k(16'h4200, 16'h4500, 16'h4B80, 2'b00);
        issue_k(16'hC900, 16'h4800, 16'hD500, 2'b00);
        issue_k(16'h7BFF, 16'h7BFF, 16'h7C00, 2'b01);
        issue_k(16'h0400, 16'h0400, 16'h0000, 2'b10);
`ifdef FP_MUL_RNE_EN
        issue_k(16'h3E01, 16'h3E01, 16'h4082, 2'b00);
`else
        issue_k(16'h3E01, 16'h3E01, 16'h4081, 2'b00);
`endif
        issue_k(16'h3800, 16'h0000, 16'h0000, 2'b00);
        issue_k(16'hFC00, 16'h0401, 16'hFE00, 2'b11);
        drain();

        // Backpressure, then a back-to-back accept right after release.
        out_ready = 1'b0;
        issue_k(16'h3C00, 16'h4000, 16'h4000, 2'b00);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got out_valid=0 required 1 within 50 cycles");
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        issue_k(16'h4000, 16'h4000, 16'h4400, 2'b00);
        chk("back_to_back_accept", 32'(last_acc), 32'(rel + 1));
        drain();

        // Reset during Booth iteration 3 discards the operation.
        issue(16'h4200, 16'h4500);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        issue_k(16'h3C00, 16'h3C00, 16'h3C00, 2'b00);
        drain();

        bp_mode = 1'b1;
        for (int i = 0; i < 80; i++) issue(rand_op(), rand_op());
        bp_mode = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
